// File: rtl/word_mux_rr_sched.sv
// word_mux_rr_sched: round-robin scheduler for a shared pipelined word mux,
// with an optional per-lane burst allowance and a {valid, id} shadow pipe.
`default_nettype none

module word_mux_rr_sched #(
    parameter int WORDS_IN    = 16,
    parameter int SEL_NUM     = $clog2(WORDS_IN),
    parameter int MUX_LATENCY = 2,
    parameter int BURST       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [WORDS_IN-1:0] req,
    output logic [WORDS_IN-1:0] grant,
    output logic [SEL_NUM-1:0]  mux_sel,
    output logic                mux_ena,
    output logic                out_valid,
    output logic [SEL_NUM-1:0]  out_id,
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(BURST + 1);

    logic               adv;
    logic [SEL_NUM-1:0] ptr;
    logic [SEL_NUM-1:0] last_id;
    logic [SEL_NUM-1:0] sel_hold;
    logic [CNT_W-1:0]   burst_cnt;
    logic               burst_cont;
    logic               win_found;
    logic [SEL_NUM-1:0] win_id;
    logic [SEL_NUM-1:0] scan_idx;

    // A nonzero burst count means the previous advancing edge granted last_id.
    always_comb begin
        burst_cont = (burst_cnt != '0) && req[last_id] && (burst_cnt < CNT_W'(BURST));
        win_found  = 1'b0;
        win_id     = ptr;
        scan_idx   = ptr;
        if (burst_cont) begin
            win_found = 1'b1;
            win_id    = last_id;
        end else begin
            for (int i = 0; i < WORDS_IN; i++) begin
                scan_idx = ptr + SEL_NUM'(i);
                if (!win_found && req[scan_idx]) begin
                    win_found = 1'b1;
                    win_id    = scan_idx;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (adv && win_found) begin
            grant[win_id] = 1'b1;
        end
    end

    assign mux_sel = (adv && win_found) ? win_id : sel_hold;
    assign mux_ena = adv;

    // Pointer always moves past the winner; mid-burst the burst rule overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            last_id   <= '0;
            sel_hold  <= '0;
            burst_cnt <= '0;
        end else if (adv) begin
            if (win_found) begin
                sel_hold  <= win_id;
                last_id   <= win_id;
                ptr       <= win_id + SEL_NUM'(1);
                burst_cnt <= burst_cont ? burst_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                burst_cnt <= '0;
            end
        end
    end

    generate
        if (MUX_LATENCY == 0) begin : g_comb
            assign out_valid = |grant;
            assign out_id    = mux_sel;
            assign adv       = ena & ~rst;
        end else begin : g_pipe
            logic [MUX_LATENCY-1:0] vld;
            logic [SEL_NUM-1:0]     ids [MUX_LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= '0;
                    for (int i = 0; i < MUX_LATENCY; i++) begin
                        ids[i] <= '0;
                    end
                end else if (adv) begin
                    vld[0] <= |grant;
                    ids[0] <= mux_sel;
                    for (int i = 1; i < MUX_LATENCY; i++) begin
                        vld[i] <= vld[i-1];
                        ids[i] <= ids[i-1];
                    end
                end
            end

            assign out_valid = vld[MUX_LATENCY-1];
            assign out_id    = ids[MUX_LATENCY-1];
            assign adv       = ena & ~rst & (~out_valid | out_ready);
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_word_mux_rr_sched.sv
// tb_word_mux_rr_sched: directed checks of arbitration, burst, stall, bubbles and reset.
`default_nettype none

module tb_word_mux_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] req_a, req_b;
    logic        ready_a, ready_b;
    logic [15:0] grant_a, grant_b;
    logic [3:0]  sel_a, sel_b, id_a, id_b;
    logic        mena_a, mena_b, vld_a, vld_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_mux_rr_sched #(.WORDS_IN(16), .MUX_LATENCY(2), .BURST(1)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .req(req_a), .grant(grant_a),
        .mux_sel(sel_a), .mux_ena(mena_a), .out_valid(vld_a), .out_id(id_a),
        .out_ready(ready_a)
    );

    word_mux_rr_sched #(.WORDS_IN(16), .MUX_LATENCY(2), .BURST(3)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .req(req_b), .grant(grant_b),
        .mux_sel(sel_b), .mux_ena(mena_b), .out_valid(vld_b), .out_id(id_b),
        .out_ready(ready_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; req_a = '0; req_b = '0; ready_a = 1'b1; ready_b = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if ({grant_a, sel_a, vld_a, id_a} !== 25'd0) begin
            errors++;
            $display("FAIL reset_a: grant=%h sel=%0d vld=%b id=%0d, want all 0", grant_a, sel_a, vld_a, id_a);
        end
        checks++;
        if ({grant_b, sel_b, vld_b, id_b} !== 25'd0) begin
            errors++;
            $display("FAIL reset_b: grant=%h sel=%0d vld=%b id=%0d, want all 0", grant_b, sel_b, vld_b, id_b);
        end
        tick();
        rst = 1'b0;
    endtask

    // Cycles c0..c19: every lane requesting; grants 0..15,0..3.
    task automatic test_round_robin();
        logic [15:0] eg;
        req_a = 16'hFFFF;
        for (int c = 0; c < 20; c++) begin
            #1;
            eg = 16'd1 << (c % 16);
            checks++;
            if (grant_a !== eg || sel_a !== 4'(c % 16) || mena_a !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant c%0d: grant=%h sel=%0d ena=%b, want %h %0d 1", c, grant_a, sel_a, mena_a, eg, c % 16);
            end
            checks++;
            if (vld_a !== (c >= 2) || (c >= 2 && id_a !== 4'((c - 2) % 16))) begin
                errors++;
                $display("FAIL rr_out c%0d: vld=%b id=%0d, want %b %0d", c, vld_a, id_a, c >= 2, (c - 2) % 16);
            end
            tick();
        end
    endtask

    // c20..c22: only lanes 5 and 3 with ptr at 4.
    task automatic test_pointer_skip();
        int exp_lane [3] = '{5, 3, 5};
        req_a = 16'h0028;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (grant_a !== (16'd1 << exp_lane[c]) || sel_a !== 4'(exp_lane[c])) begin
                errors++;
                $display("FAIL skip c%0d: grant=%h sel=%0d, want lane %0d", c, grant_a, sel_a, exp_lane[c]);
            end
            tick();
        end
    endtask

    // c23..c33: grants 6,7, four stalled cycles, release, one ena=0 cycle.
    task automatic test_stall();
        int          g_lane [11] = '{6, 7, -1, -1, -1, -1, 8, 9, -1, 10, 11};
        int          o_id   [11] = '{3, 5, 6, 6, 6, 6, 6, 7, 8, 8, 9};
        logic        rdy    [11] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic        en     [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        logic [15:0] eg;
        req_a = 16'hFFFF;
        for (int c = 0; c < 11; c++) begin
            ready_a = rdy[c];
            ena     = en[c];
            #1;
            eg = (g_lane[c] < 0) ? 16'd0 : (16'd1 << g_lane[c]);
            checks++;
            if (grant_a !== eg || mena_a !== (g_lane[c] >= 0)) begin
                errors++;
                $display("FAIL stall_grant c%0d: grant=%h ena=%b, want %h %b", c, grant_a, mena_a, eg, g_lane[c] >= 0);
            end
            checks++;
            if (vld_a !== 1'b1 || id_a !== 4'(o_id[c])) begin
                errors++;
                $display("FAIL stall_out c%0d: vld=%b id=%0d, want 1 %0d", c, vld_a, id_a, o_id[c]);
            end
            if (g_lane[c] < 0 && en[c]) begin
                checks++;
                if (sel_a !== 4'd7) begin
                    errors++;
                    $display("FAIL stall_sel_hold c%0d: sel=%0d, want 7", c, sel_a);
                end
            end
            tick();
        end
        ena = 1'b1;
        ready_a = 1'b1;
    endtask

    // c34..c40: three request-free cycles produce three bubbles; ptr stays at 13.
    task automatic test_bubbles();
        logic [15:0] rq   [7] = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        int          g_ln [7] = '{12, -1, -1, -1, 13, 14, 15};
        logic        o_v  [7] = '{1, 1, 1, 0, 0, 0, 1};
        int          o_id [7] = '{10, 11, 12, 0, 0, 0, 13};
        logic [15:0] eg;
        for (int c = 0; c < 7; c++) begin
            req_a = rq[c];
            #1;
            eg = (g_ln[c] < 0) ? 16'd0 : (16'd1 << g_ln[c]);
            checks++;
            if (grant_a !== eg || mena_a !== 1'b1) begin
                errors++;
                $display("FAIL bubble_grant c%0d: grant=%h ena=%b, want %h 1", c, grant_a, mena_a, eg);
            end
            checks++;
            if (vld_a !== o_v[c] || (o_v[c] && id_a !== 4'(o_id[c]))) begin
                errors++;
                $display("FAIL bubble_out c%0d: vld=%b id=%0d, want %b %0d", c, vld_a, id_a, o_v[c], o_id[c]);
            end
            tick();
        end
    endtask

    // c41: lanes 14 and 15 in flight when reset hits mid-cycle.
    task automatic test_reset_flight();
        #1;
        checks++;
        if (vld_a !== 1'b1 || id_a !== 4'd14) begin
            errors++;
            $display("FAIL flight_pre: vld=%b id=%0d, want 1 14", vld_a, id_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (vld_a !== 1'b0 || grant_a !== 16'd0 || sel_a !== 4'd0 || id_a !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: vld=%b grant=%h sel=%0d id=%0d, want 0 0 0 0", vld_a, grant_a, sel_a, id_a);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (grant_a !== 16'h0001 || sel_a !== 4'd0 || vld_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first: grant=%h sel=%0d vld=%b, want 0001 0 0", grant_a, sel_a, vld_a);
        end
        tick();
        checks++;
        if (grant_a !== 16'h0002 || vld_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_second: grant=%h vld=%b, want 0002 0", grant_a, vld_a);
        end
        tick();
        checks++;
        if (vld_a !== 1'b1 || id_a !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_out: vld=%b id=%0d, want 1 0", vld_a, id_a);
        end
    endtask

    // BURST=3 instance, fresh from reset: bursts of three, then req[0] dropped mid-burst.
    task automatic test_burst();
        logic [15:0] rq [12] = '{16'h3, 16'h3, 16'h3, 16'h3, 16'h3, 16'h3,
                                 16'h3, 16'h3, 16'h2, 16'h3, 16'h3, 16'h3};
        logic [15:0] eg [12] = '{16'h1, 16'h1, 16'h1, 16'h2, 16'h2, 16'h2,
                                 16'h1, 16'h1, 16'h2, 16'h2, 16'h2, 16'h1};
        ready_b = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_b = rq[c];
            #1;
            checks++;
            if (grant_b !== eg[c] || sel_b !== ((eg[c] == 16'h2) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL burst c%0d: grant=%h sel=%0d, want %h", c, grant_b, sel_b, eg[c]);
            end
            tick();
        end
        req_b = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_pointer_skip();
        test_stall();
        test_bubbles();
        test_reset_flight();
        test_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/word_mux_rr_sched.md
Name: word_mux_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined word mux among WORDS_IN requesters.
- Each cycle it picks one requesting lane and drives the mux select and mux enable.
- It carries a valid/lane-id tag down a shadow pipeline matched to the mux latency, so downstream sees an aligned valid and source id alongside mux dout.
- Sits directly beside the mux instance, which is built with select balancing enabled.

Parameters:
- WORDS_IN, 16, number of requester lanes (power of 2, ≥2).
- SEL_NUM, log2(WORDS_IN), select width.
- MUX_LATENCY, 2, register layers in the attached mux (0 allowed = combinational mux).
- BURST, 1, max consecutive grants to one lane while its request stays high (≥1).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- ena, input, 1, global clock enable.
- req, input, WORDS_IN, per-lane request; lane i presents its word on mux din slice i while req[i] is high.
- grant, output, WORDS_IN, one-hot, combinational; lane i's word is consumed at this edge.
- mux_sel, output, SEL_NUM, select to the mux; equals the index of the set bit in grant; holds its previous value when grant is 0.
- mux_ena, output, 1, enable to the mux (= adv).
- out_valid, output, 1, mux dout is valid this cycle.
- out_id, output, SEL_NUM, lane index of the word on mux dout.
- out_ready, input, 1, downstream accepts out_valid word.

Behaviour:
- Reset (async) clears everything:
  - All outputs 0: grant 0, mux_sel 0, out_valid 0, out_id 0.
  - Priority pointer ptr 0, burst counter 0, all shadow stages invalid.
- Advance: adv = ena & (~out_valid | out_ready).
  - When adv is 0, nothing moves: pointer, burst counter, shadow stages and mux registers all hold.
  - grant is forced to 0 when adv is 0.
- Arbitration (combinational, only when adv=1):
  - Scan req starting at index ptr, upward with wrap; the first set bit wins.
  - Burst rule: if the previous grant was to lane L, req[L] is still high, and burst count < BURST, lane L wins regardless of ptr.
- State update on a grant to lane g at an adv edge:
  - Continuing a burst on the same lane: burst count increments.
  - Otherwise: burst count = 1.
  - When burst count reaches BURST, or the lane changes: ptr = (g+1) mod WORDS_IN, wrapping from WORDS_IN-1 to 0.
  - With BURST=1 this is plain round robin: ptr = g+1 every grant.
- No request at an adv edge: ptr holds, burst count clears, and a bubble (valid=0) enters the shadow pipe.
- Shadow pipeline: MUX_LATENCY stages of {valid, id}, shifted only on adv.
  - Stage 0 loads {|grant, g}.
  - out_valid/out_id come from the last stage.
  - MUX_LATENCY=0: out_valid = |grant and out_id = g, combinationally; adv then uses out_ready only through the registered path, so for MUX_LATENCY=0, adv = ena.
- Latency: a word granted at edge k appears on dout with out_valid=1 in the cycle after edge k+MUX_LATENCY-1, counting adv edges only.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipe; the granted lane is not re-granted; requesters must hold their words while ungranted.
- Simultaneous events:
  - A request can rise in the same cycle it is granted.
  - Dropping req[L] mid-burst ends the burst immediately; ptr moves to L+1.
- ena=0: behaves as a stall, regardless of out_ready.
- Reset mid-operation discards all in-flight tags; mux contents after reset are don't-care because out_valid=0.

Test Plan:
1. WORDS_IN=16, MUX_LATENCY=2, BURST=1, req=16'hFFFF, out_ready=1 → grants lanes 0,1,2,…,15,0 on consecutive cycles; out_id follows 2 cycles later; out_valid continuously 1 from cycle 2.
2. Only req[5] and req[3] high, ptr=4 → grant 5 then 3 then 5; mux_sel matches the grant index each cycle.
3. BURST=3, req=16'h0003 held → grants 0,0,0,1,1,1,0…; dropping req[0] after its 2nd grant → the next grant goes to 1 and ptr=1.
4. Continuous traffic with out_ready=0 for 4 cycles → grant=0, mux_ena=0, out_id/out_valid stable; on release, the sequence resumes with no lost or duplicated id.
5. req=0 for 3 cycles mid-stream → 3 bubbles: out_valid=0 for exactly 3 cycles after latency; ptr unchanged.
6. Assert rst while 2 words are in flight → out_valid=0, grant=0, mux_sel=0 immediately (async); after release with req=16'hFFFF, the first grant is lane 0.
